// File: rtl/fp_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
package fp_pkg;

   // Operand-pair classification decided in S1; specials bypass the arithmetic path
   typedef enum logic [1:0] {
      K_NORM = 2'd0,
      K_ZERO = 2'd1,
      K_INF  = 2'd2,
      K_NAN  = 2'd3
   } kind_t;

   // Bit positions inside flags = {invalid, overflow, underflow}
   localparam int FLAGS_W = 3;
   localparam int FLG_INV = 2;
   localparam int FLG_OVF = 1;
   localparam int FLG_UNF = 0;

   // Exponent bias for a given exponent width
   function automatic int bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/fp_round_pack.sv
// S3 combinational: normalise product, RNE round, range check and pack result + flags.
module fp_round_pack
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 7
) (
   input  logic                      sign,
   input  kind_t                     kind,
   input  logic                      inv,
   input  logic signed [EXP_W+1:0]   exp_in,
   input  logic [2*MAN_W+1:0]        p,
   output logic [EXP_W+MAN_W:0]      y,
   output logic [FLAGS_W-1:0]        flags
);
   localparam int N  = 1 + EXP_W + MAN_W;
   localparam int PW = 2*MAN_W + 2;
   localparam int EW = EXP_W + 2;
   localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] EZERO = '0;
   localparam logic [N-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   logic [PW-2:0]          pn;
   logic [MAN_W-1:0]       man;
   logic                   g, r, st, up, carry;
   logic [MAN_W:0]         man_r;
   logic signed [EW-1:0]   e_f;

   // Drop the leading one; a product in [2,4) already sits one bit higher
   assign pn    = p[PW-1] ? p[PW-2:0] : {p[PW-3:0], 1'b0};
   assign man   = pn[PW-2 -: MAN_W];
   assign g     = pn[MAN_W];
   assign r     = pn[MAN_W-1];
   assign st    = |pn[MAN_W-2:0];
   assign up    = g & (r | st | man[0]);
   assign man_r = {1'b0, man} + (MAN_W+1)'(up);
   assign carry = man_r[MAN_W];
   // On rounding carry-out man_r low bits are already zero
   assign e_f   = exp_in + EW'(p[PW-1]) + EW'(carry);

   // Specials first, then overflow/underflow on the final exponent
   always_comb begin
      y     = {sign, e_f[EXP_W-1:0], man_r[MAN_W-1:0]};
      flags = '0;
      case (kind)
         K_NAN: begin
            y              = QNAN;
            flags[FLG_INV] = inv;
         end
         K_INF:  y = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         K_ZERO: y = {sign, {(N-1){1'b0}}};
         default: begin
            if (e_f >= EMAX) begin
               y              = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               flags[FLG_OVF] = 1'b1;
            end else if (e_f <= EZERO) begin
               y              = {sign, {(N-1){1'b0}}};
               flags[FLG_UNF] = 1'b1;
            end
         end
      endcase
   end

endmodule

// File: rtl/fp_mul_pipe.sv
// 3-stage FP multiplier: S1 classify/exp sum, S2 mantissa product, S3 round/pack.
// Whole pipeline advances together; a stalled output freezes every stage.
module fp_mul_pipe
   import fp_pkg::*;
#(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 7,
   localparam int N     = 1 + EXP_W + MAN_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  a,
   input  logic [N-1:0]  b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  y,
   output logic [2:0]    flags
);
   localparam int STAGES = 3;
   localparam int PW     = 2*MAN_W + 2;
   localparam int EW     = EXP_W + 2;
   localparam logic signed [EW-1:0] BIAS = EW'(bias(EXP_W));

   logic                 rdy_en, adv, acc;
   logic [STAGES:1]      vld_pipe;

   logic [EXP_W-1:0]     ea, eb;
   logic [MAN_W-1:0]     fa, fb;
   logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_snan, b_snan;
   kind_t                kind;
   logic                 inv;
   logic signed [EW-1:0] esum;

   logic                 s1_sign, s1_inv;
   kind_t                s1_kind;
   logic signed [EW-1:0] s1_exp;
   logic [MAN_W:0]       s1_ma, s1_mb;

   logic                 s2_sign, s2_inv;
   kind_t                s2_kind;
   logic signed [EW-1:0] s2_exp;
   logic [PW-1:0]        s2_p;

   logic [N-1:0]         rp_y;
   logic [FLAGS_W-1:0]   rp_flags;

   assign adv       = !vld_pipe[STAGES] | out_ready;
   assign in_ready  = rdy_en & adv;
   assign acc       = in_valid & in_ready;
   assign out_valid = vld_pipe[STAGES];

   assign ea     = a[N-2 -: EXP_W];
   assign eb     = b[N-2 -: EXP_W];
   assign fa     = a[MAN_W-1:0];
   assign fb     = b[MAN_W-1:0];
   assign a_nan  = (&ea) & (|fa);
   assign b_nan  = (&eb) & (|fb);
   assign a_inf  = (&ea) & ~(|fa);
   assign b_inf  = (&eb) & ~(|fb);
   assign a_zero = ~(|ea);
   assign b_zero = ~(|eb);
   assign a_snan = a_nan & ~fa[MAN_W-1];
   assign b_snan = b_nan & ~fb[MAN_W-1];
   assign esum   = EW'(ea) + EW'(eb) - BIAS;

   // Special-value priority: NaN / Inf*0, then Inf, then zero (subnormals flush)
   always_comb begin
      kind = K_NORM;
      inv  = 1'b0;
      if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
         kind = K_NAN;
         inv  = a_snan | b_snan | (a_inf & b_zero) | (b_inf & a_zero);
      end else if (a_inf | b_inf) begin
         kind = K_INF;
      end else if (a_zero | b_zero) begin
         kind = K_ZERO;
      end
   end

   // Input side only opens one cycle after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdy_en <= 1'b0;
      else        rdy_en <= 1'b1;
   end

   // Stage registers; everything holds while the output is stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         s1_sign  <= 1'b0;
         s1_inv   <= 1'b0;
         s1_kind  <= K_NORM;
         s1_exp   <= '0;
         s1_ma    <= '0;
         s1_mb    <= '0;
         s2_sign  <= 1'b0;
         s2_inv   <= 1'b0;
         s2_kind  <= K_NORM;
         s2_exp   <= '0;
         s2_p     <= '0;
         y        <= '0;
         flags    <= '0;
      end else if (adv) begin
         vld_pipe <= {vld_pipe[STAGES-1:1], acc};
         s1_sign  <= a[N-1] ^ b[N-1];
         s1_inv   <= inv;
         s1_kind  <= kind;
         s1_exp   <= esum;
         s1_ma    <= {1'b1, fa};
         s1_mb    <= {1'b1, fb};
         s2_sign  <= s1_sign;
         s2_inv   <= s1_inv;
         s2_kind  <= s1_kind;
         s2_exp   <= s1_exp;
         s2_p     <= PW'(s1_ma) * PW'(s1_mb);
         y        <= rp_y;
         flags    <= rp_flags;
      end
   end

   fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_rp (
      .sign   (s2_sign),
      .kind   (s2_kind),
      .inv    (s2_inv),
      .exp_in (s2_exp),
      .p      (s2_p),
      .y      (rp_y),
      .flags  (rp_flags)
   );

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed + randomized bench for fp_mul_pipe (bfloat16 defaults), real-valued reference.
module tb_fp_mul_pipe;
   logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [15:0] a, b, y;
   logic [2:0]  flags;

   int checks   = 0;
   int failures = 0;

   fp_mul_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .flags(flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: exact real product, then RNE onto the bf16 grid; returns {flags, y}
   function automatic logic [18:0] ref_mul(input logic [15:0] ra, input logic [15:0] rb);
      int   ea, eb, fa, fb, e, fi, be;
      bit   s, na, nb, ia, ib, za, zb, sn;
      real  m, frac, rem;
      logic [7:0] be8;
      logic [6:0] fi7;
      ea = int'(ra[14:7]); eb = int'(rb[14:7]);
      fa = int'(ra[6:0]);  fb = int'(rb[6:0]);
      s  = ra[15] ^ rb[15];
      na = (ea == 255) && (fa != 0);  nb = (eb == 255) && (fb != 0);
      ia = (ea == 255) && (fa == 0);  ib = (eb == 255) && (fb == 0);
      za = (ea == 0);                 zb = (eb == 0);
      sn = (na && fa < 64) || (nb && fb < 64);
      if (na || nb || (ia && zb) || (ib && za))
         return {(sn || (ia && zb) || (ib && za)), 2'b00, 16'h7FC0};
      if (ia || ib) return {3'b000, s, 8'hFF, 7'h00};
      if (za || zb) return {3'b000, s, 15'h0000};
      m = real'((128 + fa) * (128 + fb));
      e = ea + eb - 268;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      frac = (m - 1.0) * 128.0;
      fi   = int'($floor(frac));
      rem  = frac - real'(fi);
      if (rem > 0.5 || (rem == 0.5 && (fi % 2) == 1)) fi++;
      if (fi == 128) begin fi = 0; e++; end
      be = e + 127;
      if (be >= 255) return {3'b010, s, 8'hFF, 7'h00};
      if (be <= 0)   return {3'b001, s, 15'h0000};
      be8 = 8'(be);
      fi7 = 7'(fi);
      return {3'b000, s, be8, fi7};
   endfunction

   function automatic logic [15:0] rand_op(input bit wide);
      logic [15:0] v;
      v = 16'($urandom);
      if (!wide) v[14:7] = 8'($urandom_range(110, 145));
      return v;
   endfunction

   // One isolated item with out_ready high: checks latency, y and flags
   task automatic run_one(input string tag, input logic [15:0] ta, input logic [15:0] tb2,
                          input logic [15:0] ey, input logic [2:0] ef);
      int n;
      bit seen;
      @(negedge clk);
      a = ta; b = tb2; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check({tag, " in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0; seen = 1'b0;
      while (!seen && n < 10) begin
         @(negedge clk);
         n++;
         if (out_valid) seen = 1'b1;
      end
      check({tag, " latency"}, 32'(n), 32'd3);
      check({tag, " y"}, 32'(y), 32'(ey));
      check({tag, " flags"}, 32'(flags), 32'(ef));
      @(posedge clk);
   endtask

   logic [15:0] qa[$], qb[$];
   logic [18:0] qe[$];
   logic [18:0] r;
   logic [15:0] hy, ra, rb;
   logic [2:0]  hf;
   int sent, got, cyc, drops, spur;
   bit held;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst y", 32'(y), 32'd0);
      check("rst flags", 32'(flags), 32'd0);
      check("rst in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      #1 check("in_ready before first edge", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("in_ready after release", 32'(in_ready), 32'd1);

      run_one("1.5x1.5",   16'h3FC0, 16'h3FC0, 16'h4010, 3'b000);
      run_one("tie even",  16'h3F81, 16'h3FC0, 16'h3FC2, 3'b000);
      run_one("1x-2",      16'h3F80, 16'hC000, 16'hC000, 3'b000);
      run_one("overflow",  16'h7F00, 16'h7F00, 16'h7F80, 3'b010);
      run_one("underflow", 16'h0080, 16'h0080, 16'h0000, 3'b001);
      run_one("inf x 0",   16'h7F80, 16'h0000, 16'h7FC0, 3'b100);
      run_one("-inf x 2",  16'hFF80, 16'h4000, 16'hFF80, 3'b000);
      run_one("snan",      16'h7F81, 16'h3F80, 16'h7FC0, 3'b100);
      run_one("qnan",      16'hFFC1, 16'h3F80, 16'h7FC0, 3'b000);

      // Stream of 8 random pairs with a stall window on cycles 4-9
      for (int i = 0; i < 8; i++) begin
         qa.push_back(rand_op(i % 3 == 0));
         qb.push_back(rand_op(i % 3 == 0));
         qe.push_back(ref_mul(qa[i], qb[i]));
      end
      sent = 0; got = 0; cyc = 0; drops = 0; held = 1'b0; hy = '0; hf = '0;
      while ((sent < 8 || got < 8) && cyc < 80) begin
         @(negedge clk);
         out_ready = !(cyc >= 4 && cyc <= 9);
         in_valid  = (sent < 8);
         if (sent < 8) begin a = qa[sent]; b = qb[sent]; end
         #1;
         if (held) begin
            check("stall valid held", 32'(out_valid), 32'd1);
            check("stall y held", 32'(y), 32'(hy));
            check("stall flags held", 32'(flags), 32'(hf));
         end
         if (out_valid && !out_ready) begin
            check("stall in_ready", 32'(in_ready), 32'd0);
            drops++;
         end
         if (out_valid && out_ready && got < 8) begin
            check($sformatf("stream y[%0d]", got), 32'(y), 32'(qe[got][15:0]));
            check($sformatf("stream flags[%0d]", got), 32'(flags), 32'(qe[got][18:16]));
            got++;
         end
         held = out_valid && !out_ready;
         hy = y; hf = flags;
         if (in_valid && in_ready) sent++;
         @(posedge clk);
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      check("stream items out", 32'(got), 32'd8);
      check("stream stall seen", 32'(drops > 0), 32'd1);
      spur = 0;
      repeat (4) begin @(negedge clk); if (out_valid) spur++; end
      check("stream no duplicates", 32'(spur), 32'd0);

      // Reset with three items in flight and the output stalled
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         out_ready = 1'b0; in_valid = 1'b1; a = rand_op(1'b0); b = rand_op(1'b0);
         #1 check("rst fill in_ready", 32'(in_ready), 32'd1);
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1 check("pipe full before reset", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("reset drops out_valid", 32'(out_valid), 32'd0);
      check("reset clears y", 32'(y), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      spur = 0;
      repeat (6) begin @(negedge clk); if (out_valid) spur++; end
      check("no output after reset", 32'(spur), 32'd0);
      ra = rand_op(1'b0); rb = rand_op(1'b0);
      r  = ref_mul(ra, rb);
      run_one("post-reset", ra, rb, r[15:0], r[18:16]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
